// File: rtl/uart_cmd_decoder_pkg.sv
// Shared constants, FSM state type and command classification helpers
// for the UART command-frame decoder.
//   SYNC_BYTE   : frame start marker
//   COM_*       : recognised command codes
//   CRC_POLY    : CRC-8 generator polynomial (x^8 + x^2 + x + 1)
//   ADR_RD_FLAG : ADR_H bit the host sets to mark a memory read
package uart_cmd_decoder_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam logic [7:0] COM_WREG    = 8'h00;
    localparam logic [7:0] COM_RREG    = 8'h80;
    localparam logic [7:0] COM_MEM     = 8'h81;
    localparam logic [7:0] COM_IDLE    = 8'hFF;
    localparam logic [7:0] CRC_POLY    = 8'h07;
    localparam logic [7:0] ADR_RD_FLAG = 8'h80;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_COM,
        ST_ADRH,
        ST_ADRL,
        ST_LEN,
        ST_DATA,
        ST_CRC,
        ST_READ
    } state_t;

    // COM_MEM is shared by reads and writes; the ADR_H flag disambiguates.
    function automatic logic cmd_is_write(input logic [7:0] com, input logic rd_flag);
        return (com == COM_WREG) || ((com == COM_MEM) && !rd_flag);
    endfunction

    function automatic logic cmd_is_read(input logic [7:0] com, input logic rd_flag);
        return (com == COM_RREG) || ((com == COM_MEM) && rd_flag);
    endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Bundle of all non-clock signals between the decoder, the UART and the
// register/memory block.
//   master : UART/host side (drives rx_byte, rx_vld, tx_rdy; observes the rest)
//   slave  : the decoder itself
interface uart_cmd_decoder_if;
    logic [7:0]  rx_byte;
    logic        rx_vld;
    logic        tx_rdy;
    logic [7:0]  com;
    logic [15:0] wr_adr;
    logic [15:0] rd_adr;
    logic [7:0]  rx_dat;
    logic        ce_wr_dat;
    logic        rd_strb;
    logic        frame_ok;
    logic        crc_err;
    logic        tout_err;
    logic        busy;

    modport master (
        output rx_byte, rx_vld, tx_rdy,
        input  com, wr_adr, rd_adr, rx_dat, ce_wr_dat, rd_strb,
               frame_ok, crc_err, tout_err, busy
    );

    modport slave (
        input  rx_byte, rx_vld, tx_rdy,
        output com, wr_adr, rd_adr, rx_dat, ce_wr_dat, rd_strb,
               frame_ok, crc_err, tout_err, busy
    );
endinterface

// File: rtl/uart_cmd_decoder_crc8_step.sv
// Combinational CRC-8 update for one byte, MSB first.
//   crc_in  : running CRC before this byte
//   dat_in  : byte being absorbed
//   crc_out : running CRC after this byte
module crc8_step
    import uart_cmd_decoder_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] dat_in,
    output logic [7:0] crc_out
);

    logic [7:0] c;

    // Xor the whole byte in up front, then shift out eight bits; equivalent
    // to feeding one data bit per shift.
    always_comb begin
        c = crc_in ^ dat_in;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
        end
        crc_out = c;
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Frame decoder between the UART receiver and the register/memory block.
// Frame: SYNC, COM, ADR_H, ADR_L, LEN, DATA[0..LEN-1], CRC8.
// Ports:
//   clk   : system clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : uart_cmd_decoder_if.slave
//           in : rx_byte/rx_vld (received bytes), tx_rdy (transmitter ready)
//           out: com, wr_adr, rd_adr, rx_dat, ce_wr_dat (write port),
//                rd_strb (read pacing), frame_ok/crc_err/tout_err pulses, busy
module uart_cmd_decoder
    import uart_cmd_decoder_pkg::*;
#(
    parameter int TOUT_CYC = 50000,
    parameter int TOUT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_cmd_decoder_if.slave    bus
);

    state_t              state_q, state_d;
    logic [7:0]          com_q, com_d;
    logic [15:0]         wr_adr_q, wr_adr_d;
    logic [15:0]         rd_adr_q, rd_adr_d;
    logic [7:0]          rx_dat_q, rx_dat_d;
    logic                ce_wr_dat_q, ce_wr_dat_d;
    logic                frame_ok_q, frame_ok_d;
    logic                crc_err_q, crc_err_d;
    logic                tout_err_q, tout_err_d;
    logic                busy_q, busy_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [7:0]          crc_q, crc_d;
    logic                rd_flag_q, rd_flag_d;
    logic [TOUT_W-1:0]   tout_q, tout_d;
    logic                rd_strb_prev_q, rd_strb_prev_d;

    logic [7:0]          crc_next;
    logic [7:0]          cnt_inc;
    logic [TOUT_W-1:0]   tout_inc;
    logic                tout_hit;
    logic                is_wr, is_rd;
    logic                rd_fire;
    logic                timed;

    // COM restarts the CRC from zero, so seed the step with 0 in that state.
    crc8_step u_crc8_step (
        .crc_in  ((state_q == ST_COM) ? 8'h00 : crc_q),
        .dat_in  (bus.rx_byte),
        .crc_out (crc_next)
    );

    assign cnt_inc  = cnt_q + 8'd1;
    assign tout_inc = tout_q + 1'b1;
    assign tout_hit = (tout_inc == TOUT_W'(TOUT_CYC));
    assign is_wr    = cmd_is_write(com_q, rd_flag_q);
    assign is_rd    = cmd_is_read(com_q, rd_flag_q);
    assign timed    = (state_q != ST_HUNT) && (state_q != ST_READ);

    // rd_strb must line up with the tx_rdy cycle itself, so it is decoded
    // from registered state plus tx_rdy. A strobe is never issued in the cycle
    // right after another one: rd_adr has just advanced and the memory needs
    // one cycle of stable address before its data is valid.
    assign rd_fire = (state_q == ST_READ) && bus.tx_rdy &&
                     (cnt_q < len_q) && !rd_strb_prev_q;

    always_comb begin
        state_d        = state_q;
        com_d          = com_q;
        wr_adr_d       = ce_wr_dat_q ? (wr_adr_q + 16'd1) : wr_adr_q;
        rd_adr_d       = rd_adr_q;
        rx_dat_d       = rx_dat_q;
        ce_wr_dat_d    = 1'b0;
        frame_ok_d     = 1'b0;
        crc_err_d      = 1'b0;
        tout_err_d     = 1'b0;
        len_d          = len_q;
        cnt_d          = cnt_q;
        crc_d          = crc_q;
        rd_flag_d      = rd_flag_q;
        tout_d         = '0;
        rd_strb_prev_d = rd_fire;

        if (timed) begin
            if (bus.rx_vld) begin
                tout_d = '0;
            end else if (tout_hit) begin
                tout_err_d = 1'b1;
                state_d    = ST_HUNT;
                com_d      = COM_IDLE;
            end else begin
                tout_d = tout_inc;
            end
        end

        if (rd_fire) begin
            rd_adr_d = rd_adr_q + 16'd1;
            cnt_d    = cnt_inc;
            if (cnt_inc == len_q) begin
                state_d = ST_HUNT;
                com_d   = COM_IDLE;
            end
        end

        if (bus.rx_vld) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (bus.rx_byte == SYNC_BYTE) state_d = ST_COM;
                end
                ST_COM: begin
                    com_d   = bus.rx_byte;
                    crc_d   = crc_next;
                    state_d = ST_ADRH;
                end
                ST_ADRH: begin
                    wr_adr_d[15:8] = bus.rx_byte;
                    rd_adr_d[15:8] = (com_q == COM_MEM) ? (bus.rx_byte & ~ADR_RD_FLAG)
                                                        : bus.rx_byte;
                    rd_flag_d      = |(bus.rx_byte & ADR_RD_FLAG);
                    crc_d          = crc_next;
                    state_d        = ST_ADRL;
                end
                ST_ADRL: begin
                    wr_adr_d[7:0] = bus.rx_byte;
                    rd_adr_d[7:0] = bus.rx_byte;
                    crc_d         = crc_next;
                    state_d       = ST_LEN;
                end
                ST_LEN: begin
                    len_d = bus.rx_byte;
                    cnt_d = 8'd0;
                    crc_d = crc_next;
                    // Unknown commands carry no payload and go straight to CRC.
                    if ((bus.rx_byte != 8'd0) && is_wr) state_d = ST_DATA;
                    else                                state_d = ST_CRC;
                end
                ST_DATA: begin
                    rx_dat_d    = bus.rx_byte;
                    ce_wr_dat_d = 1'b1;
                    crc_d       = crc_next;
                    cnt_d       = cnt_inc;
                    if (cnt_inc == len_q) state_d = ST_CRC;
                end
                ST_CRC: begin
                    if (bus.rx_byte == crc_q) begin
                        frame_ok_d = 1'b1;
                        if (is_rd && (len_q != 8'd0)) begin
                            state_d = ST_READ;
                            cnt_d   = 8'd0;
                        end else begin
                            state_d = ST_HUNT;
                            com_d   = COM_IDLE;
                        end
                    end else begin
                        crc_err_d = 1'b1;
                        state_d   = ST_HUNT;
                        com_d     = COM_IDLE;
                    end
                end
                ST_READ: begin
                    // Bytes arriving mid-burst are dropped.
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end

        busy_d = (state_d != ST_HUNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_HUNT;
            com_q          <= COM_IDLE;
            wr_adr_q       <= 16'd0;
            rd_adr_q       <= 16'd0;
            rx_dat_q       <= 8'd0;
            ce_wr_dat_q    <= 1'b0;
            frame_ok_q     <= 1'b0;
            crc_err_q      <= 1'b0;
            tout_err_q     <= 1'b0;
            busy_q         <= 1'b0;
            len_q          <= 8'd0;
            cnt_q          <= 8'd0;
            crc_q          <= 8'd0;
            rd_flag_q      <= 1'b0;
            tout_q         <= '0;
            rd_strb_prev_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            com_q          <= com_d;
            wr_adr_q       <= wr_adr_d;
            rd_adr_q       <= rd_adr_d;
            rx_dat_q       <= rx_dat_d;
            ce_wr_dat_q    <= ce_wr_dat_d;
            frame_ok_q     <= frame_ok_d;
            crc_err_q      <= crc_err_d;
            tout_err_q     <= tout_err_d;
            busy_q         <= busy_d;
            len_q          <= len_d;
            cnt_q          <= cnt_d;
            crc_q          <= crc_d;
            rd_flag_q      <= rd_flag_d;
            tout_q         <= tout_d;
            rd_strb_prev_q <= rd_strb_prev_d;
        end
    end

    assign bus.com       = com_q;
    assign bus.wr_adr    = wr_adr_q;
    assign bus.rd_adr    = rd_adr_q;
    assign bus.rx_dat    = rx_dat_q;
    assign bus.ce_wr_dat = ce_wr_dat_q;
    assign bus.rd_strb   = rd_fire;
    assign bus.frame_ok  = frame_ok_q;
    assign bus.crc_err   = crc_err_q;
    assign bus.tout_err  = tout_err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: write/read frames, CRC error,
// address wrap, timeout, garbage rejection and mid-frame reset.
module tb_uart_cmd_decoder;

    localparam int TOUT = 300;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_cmd_decoder_if bus();

    uart_cmd_decoder #(.TOUT_CYC(TOUT), .TOUT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [15:0] adr;
        logic [7:0]  dat;
    } wr_t;

    wr_t         wr_q[$];
    logic [15:0] rd_q[$];
    logic [7:0]  frm[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_ok = 0;
    int cnt_crc = 0;
    int cnt_tout = 0;
    logic prev_strb = 1'b0;

    // Scoreboard monitor: pops expected writes/reads as the DUT strobes.
    initial begin
        wr_t         e;
        logic [15:0] ra;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_strb = 1'b0;
            end else begin
                if (bus.frame_ok) cnt_ok++;
                if (bus.crc_err)  cnt_crc++;
                if (bus.tout_err) cnt_tout++;
                if (bus.ce_wr_dat) begin
                    n_cmp++;
                    if (wr_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL wr_unexpected: adr=%h dat=%h, none expected", bus.wr_adr, bus.rx_dat);
                    end else begin
                        e = wr_q.pop_front();
                        if ({bus.wr_adr, bus.rx_dat} !== {e.adr, e.dat}) begin
                            n_bad++;
                            $display("FAIL wr_data: got adr=%h dat=%h, want adr=%h dat=%h",
                                     bus.wr_adr, bus.rx_dat, e.adr, e.dat);
                        end
                    end
                end
                if (bus.rd_strb) begin
                    n_cmp++;
                    if (bus.tx_rdy !== 1'b1) begin
                        n_bad++;
                        $display("FAIL rd_txrdy: rd_strb with tx_rdy=%b, want 1", bus.tx_rdy);
                    end
                    n_cmp++;
                    if (prev_strb !== 1'b0) begin
                        n_bad++;
                        $display("FAIL rd_gap: consecutive rd_strb, prev=%b want 0", prev_strb);
                    end
                    n_cmp++;
                    if (rd_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL rd_unexpected: rd_adr=%h, none expected", bus.rd_adr);
                    end else begin
                        ra = rd_q.pop_front();
                        if (bus.rd_adr !== ra) begin
                            n_bad++;
                            $display("FAIL rd_adr: got %h want %h", bus.rd_adr, ra);
                        end
                    end
                end
                prev_strb = bus.rd_strb;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] crc_of_frm();
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 1; i < frm.size(); i++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ frm[i][b];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_byte = b;
        bus.rx_vld  = 1'b1;
        @(posedge clk); #1;
        bus.rx_vld  = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    // Appends CRC (optionally corrupted) to frm and sends the whole frame.
    task automatic send_frame(input logic [7:0] crc_xor);
        frm.push_back(crc_of_frm() ^ crc_xor);
        foreach (frm[i]) send_byte(frm[i]);
    endtask

    task automatic check_idle(input string tag);
        n_cmp++;
        if (bus.com !== 8'hFF) begin
            n_bad++;
            $display("FAIL %s_com: got %h want ff", tag, bus.com);
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_busy: got %b want 0", tag, bus.busy);
        end
    endtask

    task automatic check_drained(input string tag);
        n_cmp++;
        if (wr_q.size() + rd_q.size() !== 0) begin
            n_bad++;
            $display("FAIL %s_drain: %0d writes / %0d reads outstanding, want 0",
                     tag, wr_q.size(), rd_q.size());
            wr_q.delete();
            rd_q.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk); #1;
        n_cmp++;
        if ({bus.wr_adr, bus.rd_adr, bus.rx_dat, bus.ce_wr_dat, bus.rd_strb,
             bus.frame_ok, bus.crc_err, bus.tout_err} !== 45'd0) begin
            n_bad++;
            $display("FAIL reset_vals: wr=%h rd=%h dat=%h strobes=%b%b%b%b%b want all 0",
                     bus.wr_adr, bus.rd_adr, bus.rx_dat, bus.ce_wr_dat, bus.rd_strb,
                     bus.frame_ok, bus.crc_err, bus.tout_err);
        end
        check_idle("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        check_idle("post_reset");
    endtask

    task automatic test_write(input string tag);
        int ok0 = cnt_ok;
        wr_q.push_back('{adr: 16'h0001, dat: 8'h11});
        wr_q.push_back('{adr: 16'h0002, dat: 8'h22});
        frm = {8'hA5, 8'h00, 8'h00, 8'h01, 8'h02, 8'h11, 8'h22};
        send_frame(8'h00);
        n_cmp++;
        if (cnt_ok - ok0 !== 1) begin
            n_bad++;
            $display("FAIL %s_frame_ok: got %0d pulses want 1", tag, cnt_ok - ok0);
        end
        check_idle(tag);
        check_drained(tag);
    endtask

    task automatic test_read();
        int ok0 = cnt_ok;
        for (int a = 0; a < 4; a++) rd_q.push_back(16'(a));
        bus.tx_rdy = 1'b0;
        frm = {8'hA5, 8'h80, 8'h00, 8'h00, 8'h04};
        send_frame(8'h00);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            bus.tx_rdy = (i % 2 == 0);
        end
        bus.tx_rdy = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (cnt_ok - ok0 !== 1) begin
            n_bad++;
            $display("FAIL read_frame_ok: got %0d pulses want 1", cnt_ok - ok0);
        end
        check_idle("read");
        check_drained("read");
    endtask

    task automatic test_mem_read_back_to_back();
        for (int a = 0; a < 3; a++) rd_q.push_back(16'h0010 + 16'(a));
        bus.tx_rdy = 1'b1;
        frm = {8'hA5, 8'h81, 8'h80, 8'h10, 8'h03};
        send_frame(8'h00);
        repeat (12) @(posedge clk); #1;
        bus.tx_rdy = 1'b0;
        check_idle("memrd");
        check_drained("memrd");
    endtask

    task automatic test_crc_error();
        int ok0 = cnt_ok;
        int ce0 = cnt_crc;
        wr_q.push_back('{adr: 16'h0001, dat: 8'h11});
        wr_q.push_back('{adr: 16'h0002, dat: 8'h22});
        frm = {8'hA5, 8'h00, 8'h00, 8'h01, 8'h02, 8'h11, 8'h22};
        send_frame(8'h01);
        n_cmp++;
        if ((cnt_ok - ok0 !== 0) || (cnt_crc - ce0 !== 1)) begin
            n_bad++;
            $display("FAIL crc_err_pulse: frame_ok=%0d crc_err=%0d want 0/1",
                     cnt_ok - ok0, cnt_crc - ce0);
        end
        check_idle("crcerr");
        check_drained("crcerr");
    endtask

    task automatic test_wrap();
        wr_q.push_back('{adr: 16'hFFFF, dat: 8'hAA});
        wr_q.push_back('{adr: 16'h0000, dat: 8'hBB});
        frm = {8'hA5, 8'h00, 8'hFF, 8'hFF, 8'h02, 8'hAA, 8'hBB};
        send_frame(8'h00);
        check_idle("wrap");
        check_drained("wrap");
    endtask

    task automatic test_timeout();
        int k = 0;
        int t0 = cnt_tout;
        send_byte(8'hA5);
        send_byte(8'h00);
        @(posedge clk); #1;
        bus.rx_byte = 8'h00;
        bus.rx_vld  = 1'b1;
        @(posedge clk); #1;
        bus.rx_vld  = 1'b0;
        while (k < TOUT + 20) begin
            @(posedge clk); #1;
            k++;
            if (bus.tout_err) break;
        end
        n_cmp++;
        if ((k < TOUT - 1) || (k > TOUT + 1)) begin
            n_bad++;
            $display("FAIL tout_latency: tout_err after %0d cycles, want about %0d", k, TOUT);
        end
        check_idle("tout");
        repeat (2) @(posedge clk);
        n_cmp++;
        if (cnt_tout - t0 !== 1) begin
            n_bad++;
            $display("FAIL tout_count: got %0d pulses want 1", cnt_tout - t0);
        end
        test_write("after_tout");
    endtask

    task automatic test_garbage_and_reset();
        send_byte(8'h00);
        send_byte(8'h5A);
        send_byte(8'hFF);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL garbage_busy: got %b want 0", bus.busy);
        end
        test_write("after_garbage");
        wr_q.push_back('{adr: 16'h1234, dat: 8'hAA});
        frm = {8'hA5, 8'h00, 8'h12, 8'h34, 8'h05, 8'hAA};
        foreach (frm[i]) send_byte(frm[i]);
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_bad++;
            $display("FAIL middata_busy: got %b want 1", bus.busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.wr_adr, bus.rd_adr, bus.rx_dat} !== 40'd0) begin
            n_bad++;
            $display("FAIL async_reset: wr=%h rd=%h dat=%h want 0", bus.wr_adr, bus.rd_adr, bus.rx_dat);
        end
        check_idle("async_reset");
        check_drained("middata");
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        test_write("after_reset");
    endtask

    initial begin
        bus.rx_byte = 8'h00;
        bus.rx_vld  = 1'b0;
        bus.tx_rdy  = 1'b0;
        test_reset();
        test_write("write");
        test_read();
        test_mem_read_back_to_back();
        test_crc_error();
        test_wrap();
        test_timeout();
        test_garbage_and_reset();
        repeat (5) @(posedge clk);
        check_drained("final");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
